pulse_scheduler: RTL
====================

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 The block SHALL have parameter DLY_W, default 8, giving the width of the start-delay count.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the pulse-count and phase-length fields.
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-005 Port req, input, 2, per-requester service request, level-sensitive.
REQ-006 Port cfg_delay, input, DLY_W, cycles to wait before the first pulse; sampled at grant.
REQ-007 Port cfg_count, input, CNT_W, number of pulses in the burst; sampled at grant.
REQ-008 Port cfg_phase, input, CNT_W, high phase and low phase each last cfg_phase+1 cycles; sampled at grant.
REQ-009 Port gnt, output, 2, one-hot grant, held for the whole service.
REQ-010 Port busy, output, 1, high in every state except IDLE.
REQ-011 Port signal, output, 1, the registered pulse-train output.
REQ-012 Port done, output, 2, one-cycle completion strobe to the served requester.

Function
REQ-013 The FSM SHALL have the states IDLE, DELAY, HIGH, LOW and DONE.
REQ-014 IDLE: when req is nonzero at a rising edge (E0), the block SHALL register gnt, latch all cfg_* fields and enter DELAY.
REQ-015 With no request pending, the block SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: when both requests are set, the requester not served last wins.
REQ-017 After reset, requester 0 SHALL have priority.
REQ-018 The round-robin pointer SHALL update only in DONE.
REQ-019 DELAY SHALL last cfg_delay+1 cycles (E0..E0+cfg_delay).
REQ-020 If the latched count is nonzero, DELAY SHALL exit to HIGH; if it is 0, DELAY SHALL exit to DONE and signal never rises.
REQ-021 HIGH SHALL last phase+1 cycles with signal=1.
REQ-022 LOW SHALL last phase+1 cycles with signal=0.
REQ-023 On leaving LOW, the block SHALL enter HIGH if pulses remain and DONE otherwise.
REQ-024 DONE SHALL last exactly 1 cycle, with done[g]=1 for the granted index g.
REQ-025 On leaving DONE, the block SHALL return to IDLE, and gnt SHALL be 0 from that edge.
REQ-026 The block SHALL not grant in the same cycle as DONE, so there is at least one IDLE cycle between services.
REQ-027 A request that drops mid-service SHALL be ignored, and the service SHALL complete.
REQ-028 cfg_* changes after grant SHALL have no effect on the current service.
REQ-029 The delay, phase and pulse counters SHALL be down-counters that never wrap.
REQ-030 Maximum fields (all ones) SHALL produce exactly 2^DLY_W delay cycles and 2^CNT_W-1 pulses.
REQ-031 signal SHALL be glitch-free, driven from a register only.

Reset
REQ-032 While reset_n=0, state SHALL be IDLE and gnt=0, busy=0, signal=0, done=0, round-robin pointer=requester 0, counters=0.
REQ-033 Reset asserted mid-burst SHALL abort immediately (signal=0 asynchronously), with no done strobe.
REQ-034 After reset release, the first rising edge SHALL be evaluated as IDLE.

Structure
REQ-035 The state encoding and the default widths SHALL live in the shared package pulse_pkg.
REQ-036 The two-requester round-robin arbiter SHALL be the sub-module pulse_rr_arb, with inputs req, pointer and enable and a one-hot grant output.
REQ-037 All other logic SHALL reside in pulse_scheduler.

Verification
REQ-038 The bench SHALL cover: req=01 at E0, delay=2, phase=1, count=2 -> signal high at E3-E4 and E7-E8, low at E5-E6 and E9-E10, done=01 at E11, gnt=0 at E12.
REQ-039 The bench SHALL cover: req=11 held through two services -> first gnt=01, second gnt=10, third gnt=01.
REQ-040 The bench SHALL cover: count=0, delay=0 -> DELAY for 1 cycle, DONE at E1, signal never 1.
REQ-041 The bench SHALL cover: reset_n low during HIGH -> signal, gnt and busy are 0 without waiting for a clock, no done, and the next grant goes to requester 0.
REQ-042 The bench SHALL cover: cfg_count changed and req dropped at E1 -> burst still uses the latched count and completes with done.
REQ-043 The bench SHALL cover: delay=255, phase=15, count=15 -> 256 delay cycles and 15 pulses each 16 high and 16 low, with no wrap.

Source files
------------

// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse scheduler: default field widths, the FSM
// state encoding and a small one-hot helper used by the arbiter.
// -----------------------------------------------------------------------------
package pulse_pkg;

   localparam int DLY_W_DEF = 8;   // default width of the start-delay field
   localparam int CNT_W_DEF = 4;   // default width of pulse-count / phase fields

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DELAY = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_DONE  = 3'd4
   } pulse_state_e;

   // Requester index -> one-hot grant vector.
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/pulse_rr_arb.sv
// -----------------------------------------------------------------------------
// pulse_rr_arb
// Two-requester round-robin arbiter (purely combinational).
//   req    : per-requester request
//   ptr    : index of the requester that currently holds priority
//   enable : grant only when high
//   gnt    : one-hot grant, zero when disabled or nobody requests
// -----------------------------------------------------------------------------
module pulse_rr_arb
   import pulse_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       enable,
   output logic [1:0] gnt
);

   logic other;

   always_comb begin
      other = ~ptr;
      gnt   = 2'b00;
      if (enable) begin
         // The priority holder wins a tie; otherwise whoever asks is served.
         if (req[ptr]) begin
            gnt = idx_to_onehot(ptr);
         end else if (req[other]) begin
            gnt = idx_to_onehot(other);
         end
      end
   end

endmodule

// File: rtl/pulse_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_scheduler
// Serves one of two requesters at a time: waits cfg_delay+1 cycles, then
// emits cfg_count pulses, each cfg_phase+1 cycles high and cfg_phase+1 cycles
// low, then strobes done to the served requester for one cycle.
//
// Ports
//   clock, reset_n : clock (rising edge), asynchronous active-low reset
//   req            : level-sensitive requests, sampled only in IDLE
//   cfg_delay/count/phase : burst parameters, latched at grant
//   gnt            : one-hot grant, held from grant until DONE is left
//   busy           : high in every state except IDLE
//   signal         : registered pulse-train output
//   done           : one-cycle completion strobe to the served requester
//   state_dbg      : current FSM state, for observation
//
// Handshake: a requester asserts req and holds it until it sees gnt; after
// the grant the request level is ignored until the service finishes with a
// done strobe. At least one IDLE cycle separates two services.
// -----------------------------------------------------------------------------
module pulse_scheduler
   import pulse_pkg::*;
#(
   parameter int DLY_W = DLY_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       req,
   input  logic [DLY_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [CNT_W-1:0] cfg_phase,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             signal,
   output logic [1:0]       done,
   output pulse_state_e     state_dbg
);

   pulse_state_e     state_q,  state_d;
   logic [1:0]       gnt_q,    gnt_d;
   logic             busy_q,   busy_d;
   logic             signal_q, signal_d;
   logic [1:0]       done_q,   done_d;
   logic             ptr_q,    ptr_d;
   logic [DLY_W-1:0] dly_q,    dly_d;     // remaining delay cycles minus one
   logic [CNT_W-1:0] cnt_q,    cnt_d;     // pulses not yet completed
   logic [CNT_W-1:0] phase_q,  phase_d;   // latched phase length
   logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;  // remaining cycles in HIGH/LOW minus one

   logic       arb_en;
   logic [1:0] arb_gnt;

   assign arb_en = (state_q == ST_IDLE);

   pulse_rr_arb u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .enable (arb_en),
      .gnt    (arb_gnt)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      dly_d    = dly_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      ph_cnt_d = ph_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_gnt != 2'b00) begin
               gnt_d   = arb_gnt;
               dly_d   = cfg_delay;
               cnt_d   = cfg_count;
               phase_d = cfg_phase;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (dly_q == '0) begin
               if (cnt_q != '0) begin
                  state_d  = ST_HIGH;
                  ph_cnt_d = phase_q;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         ST_HIGH: begin
            if (ph_cnt_q == '0) begin
               // The pulse is complete once its high phase ends; cnt_q is
               // at least one here so this never wraps.
               state_d  = ST_LOW;
               ph_cnt_d = phase_q;
               cnt_d    = cnt_q - CNT_W'(1);
            end else begin
               ph_cnt_d = ph_cnt_q - CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (ph_cnt_q == '0) begin
               if (cnt_q != '0) begin
                  state_d  = ST_HIGH;
                  ph_cnt_d = phase_q;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               ph_cnt_d = ph_cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
            // Hand priority to the requester that was not just served.
            ptr_d   = ~gnt_q[1];
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
         end
      endcase

      // Outputs are registered copies of next-state decodes, so they change
      // exactly on the edge the state does and never glitch.
      busy_d   = (state_d != ST_IDLE);
      signal_d = (state_d == ST_HIGH);
      done_d   = (state_d == ST_DONE) ? gnt_d : 2'b00;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         gnt_q    <= 2'b00;
         busy_q   <= 1'b0;
         signal_q <= 1'b0;
         done_q   <= 2'b00;
         ptr_q    <= 1'b0;
         dly_q    <= '0;
         cnt_q    <= '0;
         phase_q  <= '0;
         ph_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         busy_q   <= busy_d;
         signal_q <= signal_d;
         done_q   <= done_d;
         ptr_q    <= ptr_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         ph_cnt_q <= ph_cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign signal    = signal_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule
